// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one single-port register memory between the SPI
// slave (requests arrive from the sclk domain) and a local host port.
// SPI requests are synchronised into clk, parked in a one-deep slot, and
// arbitrated round-robin against the host. Read data is routed back to
// whichever side issued the read.
module spi_mem_arbiter #(
    parameter int NB_DATA     = 8,
    parameter int NB_ADDR     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spi_rd_req,
    input  logic               spi_wr_req,
    input  logic [NB_ADDR-1:0] spi_addr,
    input  logic [NB_DATA-1:0] spi_wr_data,
    output logic [NB_DATA-1:0] spi_rd_data,
    output logic               spi_rd_valid,
    output logic               spi_overrun,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [NB_ADDR-1:0] host_addr,
    input  logic [NB_DATA-1:0] host_wdata,
    output logic               host_gnt,
    output logic [NB_DATA-1:0] host_rdata,
    output logic               host_rvalid,
    output logic               mem_en,
    output logic               mem_we,
    output logic [NB_ADDR-1:0] mem_addr,
    output logic [NB_DATA-1:0] mem_wdata,
    input  logic [NB_DATA-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t             state;
    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic               rd_prev, wr_prev;
    logic               rd_rise, wr_rise, any_rise;

    logic               pend_valid;
    logic               pend_we;
    logic [NB_ADDR-1:0] pend_addr;
    logic [NB_DATA-1:0] pend_wdata;

    logic               last_spi;   // 1 = SPI had the previous grant
    logic               cur_spi;    // winner of the access in flight
    logic               cur_we;
    logic               host_sel, spi_sel, grant_spi;

    // Synchronise the SPI request levels; the previous-value flop starts at 0
    // so a level already high when reset releases still counts as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sync <= '0;
            wr_sync <= '0;
            rd_prev <= 1'b0;
            wr_prev <= 1'b0;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], spi_rd_req};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], spi_wr_req};
            rd_prev <= rd_sync[SYNC_STAGES-1];
            wr_prev <= wr_sync[SYNC_STAGES-1];
        end
    end

    assign rd_rise  = rd_sync[SYNC_STAGES-1] & ~rd_prev;
    assign wr_rise  = wr_sync[SYNC_STAGES-1] & ~wr_prev;
    assign any_rise = rd_rise | wr_rise;

    // Round-robin pick: on a tie the side that did not win last time goes.
    always_comb begin
        host_sel  = host_req & (~pend_valid | last_spi);
        spi_sel   = pend_valid & (~host_req | ~last_spi);
        grant_spi = (state == IDLE) & spi_sel;
    end

    // One-deep SPI slot; a rise landing on the same cycle the slot is granted
    // refills it, otherwise a rise on a full slot is lost and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            spi_overrun <= 1'b0;
        end else begin
            if (any_rise && (!pend_valid || grant_spi)) begin
                pend_valid <= 1'b1;
                pend_we    <= wr_rise;
                pend_addr  <= spi_addr;
                pend_wdata <= spi_wr_data;
            end else if (grant_spi) begin
                pend_valid <= 1'b0;
            end
            if ((any_rise && pend_valid && !grant_spi) || (rd_rise && wr_rise))
                spi_overrun <= 1'b1;
        end
    end

    // Access sequencer: IDLE issues, ACC holds the strobe, RESP returns data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_spi     <= 1'b0;
            cur_spi      <= 1'b0;
            cur_we       <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            host_gnt     <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            spi_rd_data  <= '0;
            spi_rd_valid <= 1'b0;
        end else begin
            mem_en       <= 1'b0;
            host_gnt     <= 1'b0;
            host_rvalid  <= 1'b0;
            spi_rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_sel) begin
                        mem_en    <= 1'b1;
                        mem_we    <= host_we;
                        mem_addr  <= host_addr;
                        mem_wdata <= host_wdata;
                        host_gnt  <= 1'b1;
                        last_spi  <= 1'b0;
                        cur_spi   <= 1'b0;
                        cur_we    <= host_we;
                        state     <= ACC;
                    end else if (spi_sel) begin
                        mem_en    <= 1'b1;
                        mem_we    <= pend_we;
                        mem_addr  <= pend_addr;
                        mem_wdata <= pend_wdata;
                        last_spi  <= 1'b1;
                        cur_spi   <= 1'b1;
                        cur_we    <= pend_we;
                        state     <= ACC;
                    end
                end
                ACC: state <= RESP;
                RESP: begin
                    if (!cur_we) begin
                        if (cur_spi) begin
                            spi_rd_data  <= mem_rdata;
                            spi_rd_valid <= 1'b1;
                        end else begin
                            host_rdata  <= mem_rdata;
                            host_rvalid <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: drivers push expected memory accesses
// and read results in the order the arbitration rules predict; a negedge
// monitor pops and compares whenever the DUT strobes memory or returns data.
module tb_spi_mem_arbiter;
    localparam int NB_DATA = 8, NB_ADDR = 8, SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic reset;
    logic spi_rd_req, spi_wr_req;
    logic [NB_ADDR-1:0] spi_addr;
    logic [NB_DATA-1:0] spi_wr_data, spi_rd_data;
    logic spi_rd_valid, spi_overrun;
    logic host_req, host_we, host_gnt, host_rvalid;
    logic [NB_ADDR-1:0] host_addr;
    logic [NB_DATA-1:0] host_wdata, host_rdata;
    logic mem_en, mem_we;
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_DATA-1:0] mem_wdata;
    logic [NB_DATA-1:0] mem_rdata = '0;

    spi_mem_arbiter #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset),
        .spi_rd_req(spi_rd_req), .spi_wr_req(spi_wr_req), .spi_addr(spi_addr),
        .spi_wr_data(spi_wr_data), .spi_rd_data(spi_rd_data), .spi_rd_valid(spi_rd_valid),
        .spi_overrun(spi_overrun),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         spi;
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t       exp_acc[$];
    logic [7:0] exp_host_rd[$];
    logic [7:0] exp_spi_rd[$];
    logic [7:0] ref_mem[256];
    logic [7:0] dev_mem[256];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         rv_due = -1;
    bit         rv_spi = 1'b0;
    acc_t       mon_e;

    // Memory device attached to the DUT's port
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: accesses complete in issue order over a flat memory
    task automatic expect_acc(input bit spi, input bit we, input logic [7:0] a, input logic [7:0] d);
        acc_t e;
        e.spi = spi; e.we = we; e.addr = a; e.data = d;
        exp_acc.push_back(e);
        if (we) ref_mem[a] = d;
        else if (spi) exp_spi_rd.push_back(ref_mem[a]);
        else exp_host_rd.push_back(ref_mem[a]);
    endtask

    // Monitor: compare every memory strobe and every read return
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            rv_due = -1;
            exp_acc.delete();
            exp_host_rd.delete();
            exp_spi_rd.delete();
        end else begin
            if (mem_en) begin
                if (exp_acc.size() == 0) check("unexpected_access", 1, 0);
                else begin
                    mon_e = exp_acc.pop_front();
                    check("acc_we", 32'(mem_we), 32'(mon_e.we));
                    check("acc_addr", 32'(mem_addr), 32'(mon_e.addr));
                    if (mon_e.we) check("acc_wdata", 32'(mem_wdata), 32'(mon_e.data));
                    check("acc_host_gnt", 32'(host_gnt), 32'(!mon_e.spi));
                    if (!mon_e.we) begin
                        rv_due = cyc + 2;
                        rv_spi = mon_e.spi;
                    end
                end
            end else if (host_gnt) check("gnt_without_en", 1, 0);
            if (cyc == rv_due) begin
                check("rvalid_host", 32'(host_rvalid), 32'(!rv_spi));
                check("rvalid_spi", 32'(spi_rd_valid), 32'(rv_spi));
                if (rv_spi) begin
                    if (exp_spi_rd.size() != 0) check("spi_rd_data", 32'(spi_rd_data), 32'(exp_spi_rd.pop_front()));
                end else begin
                    if (exp_host_rd.size() != 0) check("host_rdata", 32'(host_rdata), 32'(exp_host_rd.pop_front()));
                end
            end else if (host_rvalid || spi_rd_valid) check("stray_rvalid", 1, 0);
        end
    end

    task automatic do_reset(input bit spi_lvl);
        @(negedge clk); #2;
        reset = 1'b1; host_req = 1'b0; spi_rd_req = 1'b0; spi_wr_req = spi_lvl;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic host_txn(input bit we, input logic [7:0] a, input logic [7:0] d);
        int lat = 0;
        expect_acc(1'b0, we, a, d);
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (host_gnt) lat = i;
        end
        host_req = 1'b0;
        check("host_gnt_latency", lat, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_txn(input bit we, input logic [7:0] a, input logic [7:0] d);
        int lat = 0;
        expect_acc(1'b1, we, a, d);
        @(negedge clk);
        spi_addr = a; spi_wr_data = d;
        if (we) spi_wr_req = 1'b1; else spi_rd_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) begin spi_wr_req = 1'b0; spi_rd_req = 1'b0; end
            if (mem_en && lat == 0) lat = i;
        end
        check("spi_latency", lat, SYNC_STAGES + 2);
    endtask

    logic [7:0] s_a[4], s_d[4], h_a[4], h_d[4];
    bit         h_we[4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
            dev_mem[i] = 8'(i * 7 + 3);
        end
        reset = 1'b1; spi_rd_req = 1'b0; spi_wr_req = 1'b0; spi_addr = '0; spi_wr_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_host_gnt", 32'(host_gnt), 0);
        check("rst_rvalids", 32'({host_rvalid, spi_rd_valid}), 0);
        check("rst_rdatas", 32'({host_rdata, spi_rd_data}), 0);
        check("rst_overrun", 32'(spi_overrun), 0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Directed host and SPI write/read pairs
        host_txn(1'b1, 8'h10, 8'hA5);
        host_txn(1'b0, 8'h10, 8'h00);
        spi_txn(1'b1, 8'h22, 8'h3C);
        spi_txn(1'b0, 8'h22, 8'h00);

        // Random sequential mix of both requesters
        for (int t = 0; t < 24; t++) begin
            logic [7:0] a, d;
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) host_txn(1'($urandom_range(0, 1)), a, d);
            else spi_txn(1'($urandom_range(0, 1)), a, d);
        end

        // Contention: SPI frames every 6 cycles against a continuous host
        for (int k = 0; k < 4; k++) begin
            s_a[k] = 8'($urandom_range(0, 15)); s_d[k] = 8'($urandom);
            h_a[k] = 8'($urandom_range(0, 15)); h_d[k] = 8'($urandom);
            h_we[k] = 1'($urandom_range(0, 1));
        end
        spi_addr = s_a[0]; spi_wr_data = s_d[0];
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            expect_acc(1'b1, 1'b1, s_a[k], s_d[k]);
            expect_acc(1'b0, h_we[k], h_a[k], h_d[k]);
        end
        hi = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 3) begin
                host_req = 1'b1; host_we = h_we[0]; host_addr = h_a[0]; host_wdata = h_d[0];
            end else if (host_req && host_gnt) begin
                hi++;
                if (hi < 4) begin
                    host_we = h_we[hi]; host_addr = h_a[hi]; host_wdata = h_d[hi];
                end else host_req = 1'b0;
            end
            if (n % 6 == 3) spi_wr_req = 1'b0;
            if (n % 6 == 0 && n / 6 < 4) begin
                spi_addr = s_a[n/6]; spi_wr_data = s_d[n/6]; spi_wr_req = 1'b1;
            end
        end
        check("contention_leftover", exp_acc.size(), 0);
        check("contention_overrun", 32'(spi_overrun), 0);

        // Overrun: second SPI rise while the first waits behind a host access
        expect_acc(1'b0, 1'b1, 8'h40, 8'h11);
        expect_acc(1'b1, 1'b1, 8'h41, 8'h22);
        @(negedge clk);
        spi_addr = 8'h41; spi_wr_data = 8'h22; spi_wr_req = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) spi_wr_req = 1'b0;
            if (n == 2) begin
                spi_wr_req = 1'b1;
                host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h11;
            end else if (host_req && host_gnt) host_req = 1'b0;
            if (n == 3) begin spi_addr = 8'h42; spi_wr_data = 8'h33; end
            if (n == 8) spi_wr_req = 1'b0;
        end
        check("overrun_set", 32'(spi_overrun), 1);
        check("overrun_leftover", exp_acc.size(), 0);
        host_txn(1'b0, 8'h42, 8'h00);
        host_txn(1'b0, 8'h41, 8'h00);
        check("overrun_sticky", 32'(spi_overrun), 1);

        // Simultaneous rd and wr rise: one write, overrun flagged
        do_reset(1'b0);
        check("overrun_cleared", 32'(spi_overrun), 0);
        expect_acc(1'b1, 1'b1, 8'h30, 8'h5E);
        @(negedge clk);
        spi_addr = 8'h30; spi_wr_data = 8'h5E; spi_rd_req = 1'b1; spi_wr_req = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 3) begin spi_rd_req = 1'b0; spi_wr_req = 1'b0; end
        end
        check("simul_overrun", 32'(spi_overrun), 1);
        check("simul_leftover", exp_acc.size(), 0);
        spi_txn(1'b0, 8'h30, 8'h00);

        // Reset during ACC with an SPI write parked in the slot
        expect_acc(1'b0, 1'b0, 8'h10, 8'h00);
        hi = 0;
        @(negedge clk);
        spi_addr = 8'h55; spi_wr_data = 8'h66; spi_wr_req = 1'b1;
        for (int n = 1; n <= 10 && hi == 0; n++) begin
            @(negedge clk);
            if (n == 2) begin host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; end
            if (host_gnt) hi = n;
        end
        check("midacc_gnt_seen", hi, 3);
        #2 reset = 1'b1; spi_wr_req = 1'b0; host_req = 1'b0;
        #1;
        check("midacc_mem_en", 32'(mem_en), 0);
        check("midacc_host_gnt", 32'(host_gnt), 0);
        check("midacc_overrun", 32'(spi_overrun), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midacc_rvalids", 32'({host_rvalid, spi_rd_valid}), 0);
        check("midacc_host_rdata", 32'(host_rdata), 0);
        host_txn(1'b0, 8'h55, 8'h00);
        check("final_leftover", exp_acc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Owns the single-port register memory and shares it between two requesters: the SPI slave (sclk domain) and a local host port (clk domain).
- Synchronises the SPI slave's rd_req/wr_req into clk, then holds each SPI request in a one-deep pending slot.
- Arbitrates round-robin against host requests, drives the memory port, and returns read data to the requester that issued the read.

Parameters:
NB_DATA, 8, memory word width
NB_ADDR, 8, memory address width
SYNC_STAGES, 2, flops in each SPI request synchroniser (min 2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
spi_rd_req  input  1  SPI read request, sclk domain, level, rises once per frame
spi_wr_req  input  1  SPI write request, sclk domain, level, rises once per frame
spi_addr  input  NB_ADDR  SPI address; stable from req rise until the next frame
spi_wr_data  input  NB_DATA  SPI write data; same stability as spi_addr
spi_rd_data  output  NB_DATA  read data to SPI slave; holds the last SPI read result
spi_rd_valid  output  1  one-cycle pulse when spi_rd_data updates
spi_overrun  output  1  sticky: an SPI request was lost; cleared only by reset
host_req  input  1  host access request; held until granted
host_we  input  1  1 = write, 0 = read; stable while host_req high
host_addr  input  NB_ADDR  host address; stable while host_req high
host_wdata  input  NB_DATA  host write data; stable while host_req high
host_gnt  output  1  one-cycle pulse: host access issued; host may drop or change req next cycle
host_rdata  output  NB_DATA  host read data; holds the last host read result
host_rvalid  output  1  one-cycle pulse when host_rdata updates
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  NB_ADDR  memory address
mem_wdata  output  NB_DATA  memory write data
mem_rdata  input  NB_DATA  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset: all outputs are 0, the pending slot is empty, FSM=IDLE, last_grant=HOST, synchronisers are 0. All of this takes effect immediately, including mid-access, and any pending or in-flight access is dropped.
- Synchronisers: spi_rd_req and spi_wr_req each pass through SYNC_STAGES flops. A rise is detected when the synchronised value is 1 and the previous value was 0.
  - A level already high at reset release is detected as a rise.
- Capture on a rise: the pending slot loads spi_addr and spi_wr_data, plus pend_we (1 for a write rise), and sets pend_valid.
- Simultaneous rd and wr rise: the write is captured and spi_overrun is set.
- A rise while pend_valid=1 and the slot is not being granted that cycle: the new request is dropped, the slot is unchanged, and spi_overrun is set.
- A rise in the same cycle the slot is granted: the new request is captured, with no overrun.
- FSM states: IDLE, ACC, RESP.
  - IDLE: if pend_valid or host_req, select a winner and go to ACC.
    - Only one requesting: that one wins.
    - Both requesting: the winner is the one not equal to last_grant.
    - On leaving IDLE, register mem_en=1 and mem_we/mem_addr/mem_wdata from the winner, and update last_grant.
    - If SPI wins: clear pend_valid. If host wins: register host_gnt=1.
  - ACC (1 cycle): mem_en=1, and host_gnt=1 if the host is the winner. Next state is RESP. mem_en and host_gnt return to 0.
  - RESP (1 cycle): for a read, register mem_rdata into the winner's rdata and pulse the winner's rvalid in the following cycle. Next state is IDLE.
  - Writes produce no rvalid and leave the rdata outputs unchanged.
- Latency: a request seen in IDLE at cycle T gives mem_en at T+1, mem_rdata at T+2, and rdata/rvalid at T+3. The next arbitration decision is at T+3, so the next mem_en is at T+4. Peak throughput is one access per 3 cycles.
- SPI latency: from the spi_*_req rise in the sclk domain to mem_en takes SYNC_STAGES+2 clk cycles, plus arbitration wait (at most one host access, i.e. 3 cycles).
- The host is never starved: with both sides continuously requesting, grants alternate.
- A host_req asserted while the FSM is in ACC or RESP waits for IDLE.
- mem_addr, mem_we and mem_wdata hold their values outside ACC. Only mem_en qualifies them.

Test Plan:
- Host write then read: host write addr 0x10, data 0xA5 → mem_en/mem_we pulse 1 cycle with addr 0x10, data 0xA5, host_gnt in the same cycle. Host read of 0x10 → host_rvalid 3 cycles after the decision, host_rdata=0xA5. spi_rd_valid stays 0.
- SPI write then read: spi_wr_req rise with addr 0x22, data 0x3C → mem write to 0x22 within SYNC_STAGES+2 clk. spi_rd_req rise at 0x22 → spi_rd_valid pulse, spi_rd_data=0x3C, host_rvalid stays 0.
- Contention: host_req held continuously while SPI requests arrive, starting after reset → first tie goes to SPI, then grants alternate SPI/host. No request is lost and spi_overrun stays 0.
- Overrun: a second spi_wr_req rise while the first is still pending behind a host access → spi_overrun=1, only the first write reaches memory. spi_overrun stays 1 until reset.
- Simultaneous rd and wr rise: → a single write is issued and spi_overrun=1.
- Reset mid-access: assert reset during ACC → mem_en, host_gnt and rvalid go 0 immediately, the pending slot is cleared, and no access follows release unless it is newly requested.
